// File: rtl/ram_cnt_ctrl.sv
// Seconds-count recorder: counts clk1Hz rising edges (sampled as data in the clk50M domain) and logs each count to an external RAM.
// Define RAM_CNT_BCD_EN to count in packed BCD (DW must be 8); default build counts in plain binary.
//
// state | meaning
// IDLE  | not logging; waits for run or a read-back request
// RUN   | counting; waits for the next tick to log
// WRITE | one-cycle RAM write of the new count
// FULL  | log holds 2**AW entries; counting continues, no writes
// READ  | replays logged entries 0..N-1, one per cycle
module ram_cnt_ctrl #(
    parameter int DW      = 8,
    parameter int AW      = 4,
    parameter int CNT_MAX = 59
) (
    input  logic          clk50M,
    input  logic          Reset,
    input  logic          clk1Hz,
    input  logic          run,
    input  logic          clr,
    input  logic          rd_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] cnt,
    output logic          full,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, RUN, WRITE, FULL, READ} state_t;

    localparam logic [AW-1:0] LAST = '1;
`ifdef RAM_CNT_BCD_EN
    localparam logic [DW-1:0] TERM = DW'(((CNT_MAX / 10) << 4) | (CNT_MAX % 10));
`else
    localparam logic [DW-1:0] TERM = DW'(CNT_MAX);
`endif

    state_t        state, state_nxt;
    logic          s1, s2, s3;
    logic          tick;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_done;
    logic          rd_last;
    logic          log_nonempty;
    logic [DW-1:0] cnt_inc;
    logic [DW-1:0] cnt_nxt;

    assign tick         = s2 & ~s3;
    assign log_nonempty = full | (wr_ptr != '0);
    // With full flagged, wr_ptr parks at LAST, so the last entry to replay is LAST itself
    assign rd_last      = full ? (rd_ptr == LAST) : (rd_ptr == wr_ptr - AW'(1));

    always_comb begin
        cnt_inc = cnt + DW'(1);
`ifdef RAM_CNT_BCD_EN
        if (cnt[3:0] == 4'd9)
            cnt_inc = {cnt[DW-1:4] + (DW-4)'(1), 4'd0};
`endif
        cnt_nxt = (cnt == TERM) ? '0 : cnt_inc;
    end

    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_req && log_nonempty)
                    state_nxt = READ;
                else if (run)
                    state_nxt = RUN;
            end
            RUN: begin
                if (!run)
                    state_nxt = IDLE;
                else if (tick)
                    state_nxt = WRITE;
            end
            WRITE:   state_nxt = (wr_ptr == LAST) ? FULL : RUN;
            FULL:    if (rd_req) state_nxt = READ;
            READ:    if (rd_done) state_nxt = full ? FULL : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= '0;
            full     <= 1'b0;
            rd_ptr   <= '0;
            rd_done  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            s1 <= clk1Hz;
            s2 <= s1;
            s3 <= s2;
            if (clr) begin
                cnt      <= '0;
                wr_ptr   <= '0;
                full     <= 1'b0;
                rd_ptr   <= '0;
                rd_done  <= 1'b0;
                rd_valid <= 1'b0;
            end else begin
                if (tick && run)
                    cnt <= cnt_nxt;
                if (state == WRITE) begin
                    if (wr_ptr == LAST)
                        full <= 1'b1;
                    else
                        wr_ptr <= wr_ptr + AW'(1);
                end
                rd_valid <= (state == READ) && !rd_done;
                // rd_done holds READ one extra cycle so the last rd_valid lands while busy
                if (state == READ) begin
                    if (!rd_done) begin
                        if (rd_last)
                            rd_done <= 1'b1;
                        else
                            rd_ptr <= rd_ptr + AW'(1);
                    end
                end else begin
                    rd_ptr  <= '0;
                    rd_done <= 1'b0;
                end
            end
        end
    end

    assign ram_we    = (state == WRITE) && !clr;
    assign ram_wdata = (state == WRITE) ? cnt : '0;
    assign ram_addr  = (state == WRITE) ? wr_ptr :
                       ((state == READ) && !rd_done) ? rd_ptr : '0;
    assign rd_data   = rd_valid ? ram_rdata : '0;
    assign busy      = (state == WRITE) || (state == READ);

endmodule

// File: tb/tb_ram_cnt_ctrl.sv
// Scoreboard bench for ram_cnt_ctrl with a behavioural synchronous RAM; honours RAM_CNT_BCD_EN when defined.
module tb_ram_cnt_ctrl;

    localparam int DW      = 8;
    localparam int AW      = 6;
    localparam int CNT_MAX = 59;
    localparam int DEPTH   = 1 << AW;

    logic          clk50M = 1'b0;
    logic          Reset;
    logic          clk1Hz;
    logic          run;
    logic          clr;
    logic          rd_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] cnt;
    logic          full;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;

    ram_cnt_ctrl #(.DW(DW), .AW(AW), .CNT_MAX(CNT_MAX)) dut (
        .clk50M    (clk50M),
        .Reset     (Reset),
        .clk1Hz    (clk1Hz),
        .run       (run),
        .clr       (clr),
        .rd_req    (rd_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .cnt       (cnt),
        .full      (full),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy)
    );

    always #10 clk50M = ~clk50M;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk50M) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] logm [DEPTH];
    int            nlog = 0;
    logic [DW-1:0] mcnt = '0;
    int            checks = 0;
    int            failures = 0;
    int            rd_seen = 0;
    bit            we_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] nxt(input logic [DW-1:0] v);
`ifdef RAM_CNT_BCD_EN
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
`else
        if (v == DW'(CNT_MAX)) return '0;
        return v + DW'(1);
`endif
    endfunction

    // Monitor: pops expected writes / read-back values whenever the DUT presents them
    always @(negedge clk50M) begin
        if (!Reset) begin
            if (ram_we) begin
                chk("we_pulse_width", {31'd0, we_prev}, 32'd0);
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0h required=no_write", ram_addr, ram_wdata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(e.a));
                    chk("wr_data", 32'(ram_wdata), 32'(e.d));
                end
            end
            we_prev = ram_we;
            if (rd_valid) begin
                rd_seen++;
                chk("busy_during_rd_valid", {31'd0, busy}, 32'd1);
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rd_valid data=%0h required=no_valid", rd_data);
                end else begin
                    logic [DW-1:0] d;
                    d = exp_rd.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(d));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk50M);
            #2;
        end
    endtask

    task automatic tick(input bit logged);
        wr_t e;
        mcnt = nxt(mcnt);
        if (logged) begin
            e.a = AW'(nlog);
            e.d = mcnt;
            exp_wr.push_back(e);
            logm[nlog] = mcnt;
            nlog++;
        end
        clk1Hz = 1'b1;
        cyc(4);
        clk1Hz = 1'b0;
        cyc(4);
    endtask

    task automatic readback();
        bit done;
        for (int i = 0; i < nlog; i++)
            exp_rd.push_back(logm[i]);
        rd_req = 1'b1;
        cyc(1);
        rd_req = 1'b0;
        chk("busy_read_start", {31'd0, busy}, 32'd1);
        done = 1'b0;
        for (int k = 0; k < DEPTH + 10; k++) begin
            cyc(1);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("read_completes", {31'd0, done}, 32'd1);
        chk("read_all_values_seen", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  base;
        bit  got;
        Reset = 1'b1;
        clk1Hz = 1'b0;
        run = 1'b0;
        clr = 1'b0;
        rd_req = 1'b0;
        cyc(3);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        Reset = 1'b0;
        cyc(2);

        // Fill the whole log; tick 60 wraps 59 -> 0 and logs the 0
        run = 1'b1;
        cyc(2);
        chk("busy_in_run", {31'd0, busy}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1);
            chk("cnt_after_tick", 32'(cnt), 32'(mcnt));
            if (i == 60)
                chk("cnt_wrap_to_zero", 32'(cnt), 32'd0);
`ifdef RAM_CNT_BCD_EN
            if (i == 10)
                chk("bcd_09_to_10", 32'(cnt), 32'h10);
`endif
            if (i < DEPTH)
                chk("full_not_yet", {31'd0, full}, 32'd0);
        end
        chk("full_set", {31'd0, full}, 32'd1);
        chk("busy_in_full", {31'd0, busy}, 32'd0);
        tick(1'b0);
        chk("cnt_counts_in_full", 32'(cnt), 32'(mcnt));
        chk("full_holds", {31'd0, full}, 32'd1);
        cyc(4);
        chk("writes_all_seen", 32'(exp_wr.size()), 32'd0);

        readback();
        chk("full_after_read", {31'd0, full}, 32'd1);

        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        mcnt = '0;
        nlog = 0;
        chk("clr_cnt", 32'(cnt), 32'd0);
        chk("clr_full", {31'd0, full}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);

        // Five entries, then two identical replays
        cyc(2);
        for (int i = 0; i < 5; i++)
            tick(1'b1);
        chk("cnt_after_5", 32'(cnt), 32'd5);
        run = 1'b0;
        cyc(3);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        readback();
        readback();

        // clr while the 3rd entry is on rd_data: only 3 values ever appear
        base = rd_seen;
        for (int i = 0; i < 3; i++)
            exp_rd.push_back(logm[i]);
        rd_req = 1'b1;
        cyc(1);
        rd_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk50M);
            #1;
            if (rd_seen >= base + 3) begin
                got = 1'b1;
                break;
            end
        end
        chk("third_entry_reached", {31'd0, got}, 32'd1);
        clr = 1'b1;
        @(posedge clk50M);
        #2;
        clr = 1'b0;
        mcnt = '0;
        nlog = 0;
        chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_cnt", 32'(cnt), 32'd0);
        chk("abort_full", {31'd0, full}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        cyc(4);
        chk("abort_value_count", 32'(rd_seen - base), 32'd3);

        // Empty log: rd_req is ignored
        rd_req = 1'b1;
        cyc(1);
        rd_req = 1'b0;
        chk("empty_rd_ignored_busy", {31'd0, busy}, 32'd0);
        cyc(5);
        chk("empty_rd_ignored_valid", 32'(rd_seen - base), 32'd3);

        // After clr the next write lands at address 0
        run = 1'b1;
        cyc(2);
        tick(1'b1);
        chk("cnt_after_clr_tick", 32'(cnt), 32'd1);
        cyc(3);
        chk("final_writes_seen", 32'(exp_wr.size()), 32'd0);
        chk("final_reads_seen", 32'(exp_rd.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
